shift_round_sat: RTL and testbench

SHIFT_ROUND_SAT -- requirements
Module: shift_round_sat

---
 rtl/shift_round_sat.sv | 156 +++++++++++++++
 tb/tb_shift_round_sat.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_round_sat.sv
// Per-lane arithmetic right shift with optional round-half-up, then saturation
// to a narrower signed width; 2-stage valid/ready pipeline plus a saturation counter.

module shift_round_sat_lane #(
  parameter int IN_WIDTH  = 16,
  parameter int SH_WIDTH  = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        s1_en,
  input  logic                        s2_en,
  input  logic signed [IN_WIDTH-1:0]  x,
  input  logic        [SH_WIDTH-1:0]  sh,
  input  logic                        rnd,
  output logic signed [OUT_WIDTH-1:0] d,
  output logic                        sat
);
  // wide enough to hold both the raw shift and the clamp value IN_WIDTH
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int EW = (SH_WIDTH > CW) ? SH_WIDTH : CW;

  logic        [EW-1:0]       sh_e, s;
  logic signed [IN_WIDTH-1:0] xa;
  logic        [IN_WIDTH-1:0] xm;
  logic                       inc;
  logic signed [IN_WIDTH:0]   r1, s1_q;
  logic signed [OUT_WIDTH-1:0] sat_d;
  logic                       sat_f;

  always_comb begin
    sh_e = EW'(sh);
    s    = (sh_e > EW'(IN_WIDTH)) ? EW'(IN_WIDTH) : sh_e;
    xa   = x >>> s;
    // bit (s-1) of x is the first bit shifted out; it is the half-up increment
    xm   = x >> (s - EW'(1));
    inc  = rnd && (s != '0) && xm[0];
    r1   = {xa[IN_WIDTH-1], xa} + {{IN_WIDTH{1'b0}}, inc};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   s1_q <= '0;
    else if (s1_en) s1_q <= r1;
  end

  generate
    if (OUT_WIDTH >= IN_WIDTH + 1) begin : g_ext
      always_comb begin
        sat_d = OUT_WIDTH'(s1_q);
        sat_f = 1'b0;
      end
    end else begin : g_clamp
      logic [IN_WIDTH-OUT_WIDTH+1:0] hi;
      always_comb begin
        hi    = s1_q[IN_WIDTH:OUT_WIDTH-1];
        sat_f = !((&hi) || !(|hi));
        if (!sat_f)         sat_d = s1_q[OUT_WIDTH-1:0];
        else if (s1_q[IN_WIDTH]) sat_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else                sat_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d   <= '0;
      sat <= 1'b0;
    end else if (s2_en) begin
      d   <= sat_d;
      sat <= sat_f;
    end
  end
endmodule

module shift_round_sat #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int SH_WIDTH  = 4,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [LANES*IN_WIDTH-1:0]      i_data,
  input  logic [LANES*SH_WIDTH-1:0]      i_shift,
  input  logic                           i_round,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [LANES*OUT_WIDTH-1:0]     o_data,
  output logic [LANES-1:0]               o_sat,
  input  logic                           i_cnt_clr,
  output logic [CNT_WIDTH-1:0]           o_sat_cnt
);
  localparam int STAGES = 2;

  logic [LANES-1:0][IN_WIDTH-1:0]  x_v;
  logic [LANES-1:0][SH_WIDTH-1:0]  sh_v;
  logic [LANES-1:0][OUT_WIDTH-1:0] d_v;
  logic [LANES-1:0]                sat_v;
  logic [STAGES:1]                 vld_pipe;
  logic                            s1_adv, s2_adv, s1_en, s2_en, out_fire;

  assign x_v  = i_data;
  assign sh_v = i_shift;

  // ready depends only on pipeline state and i_ready, never on i_valid
  assign s2_adv   = !vld_pipe[2] || i_ready;
  assign s1_adv   = !vld_pipe[1] || s2_adv;
  assign o_ready  = s1_adv;
  assign s1_en    = s1_adv && i_valid;
  assign s2_en    = s2_adv && vld_pipe[1];
  assign out_fire = vld_pipe[2] && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= i_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      shift_round_sat_lane #(
        .IN_WIDTH (IN_WIDTH),
        .SH_WIDTH (SH_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
      ) u_lane (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .s1_en  (s1_en),
        .s2_en  (s2_en),
        .x      (x_v[k]),
        .sh     (sh_v[k]),
        .rnd    (i_round),
        .d      (d_v[k]),
        .sat    (sat_v[k])
      );
    end
  endgenerate

  assign o_valid = vld_pipe[2];
  assign o_data  = d_v;
  assign o_sat   = sat_v;

  // clear wins over increment; the count sticks at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  o_sat_cnt <= '0;
    else if (i_cnt_clr)                            o_sat_cnt <= '0;
    else if (out_fire && (|o_sat) && !(&o_sat_cnt)) o_sat_cnt <= o_sat_cnt + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_shift_round_sat.sv
// Table vectors and random streams through shift_round_sat, checked against a
// reference model via an expected-result queue and a saturation-counter model.

module tb_shift_round_sat;
  localparam int LANES = 4, IW = 16, SW = 4, OW = 8, CW = 4;
  localparam int DW = LANES*IW, SHW = LANES*SW, OD = LANES*OW;

  logic            i_clk, i_rst_n, i_valid, o_ready, i_round, o_valid, i_ready, i_cnt_clr;
  logic [DW-1:0]   i_data;
  logic [SHW-1:0]  i_shift;
  logic [OD-1:0]   o_data;
  logic [LANES-1:0] o_sat;
  logic [CW-1:0]   o_sat_cnt;

  shift_round_sat #(.LANES(LANES), .IN_WIDTH(IW), .SH_WIDTH(SW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_shift(i_shift), .i_round(i_round), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat), .i_cnt_clr(i_cnt_clr),
    .o_sat_cnt(o_sat_cnt));

  typedef struct { int x; int sh; bit rnd; int exp; bit esat; } vec_t;
  typedef struct { logic [OD-1:0] d; logic [LANES-1:0] sat; int cyc; bit lat; } exp_t;

  exp_t  q[$];
  exp_t  next_exp;
  vec_t  tbl[14];
  int    checks = 0, errors = 0, cyc = 0, nout = 0;
  bit    lat_chk = 1, saw_ordy_low = 0, held = 0;
  logic [OD+LANES-1:0] prev_out;
  logic [CW-1:0] exp_cnt = '0;

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model(input int x, input int sh, input bit rnd, output int r, output bit s);
    int se; longint v; int hi, lo;
    se = (sh > IW) ? IW : sh;
    v = x;
    if (rnd && se > 0) v = v + (longint'(1) << (se - 1));
    v = v >>> se;
    hi = (1 << (OW-1)) - 1; lo = -(1 << (OW-1));
    s = 0; r = int'(v);
    if (v > hi) begin r = hi; s = 1; end
    if (v < lo) begin r = lo; s = 1; end
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] d, input logic [SHW-1:0] sh, input bit rnd);
    exp_t e; int r; bit s; logic [IW-1:0] xv; logic [SW-1:0] sv;
    e.d = '0; e.sat = '0; e.cyc = 0; e.lat = 0;
    for (int k = 0; k < LANES; k++) begin
      xv = d[k*IW +: IW]; sv = sh[k*SW +: SW];
      model(int'($signed(xv)), int'(sv), rnd, r, s);
      e.d[k*OW +: OW] = r[OW-1:0];
      e.sat[k] = s;
    end
    return e;
  endfunction

  // runs every negedge: input capture, output scoreboard, stall hold, counter model
  task automatic monitor();
    exp_t e; bit fire; bit esat;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        q.delete(); exp_cnt = '0; held = 0;
      end else begin
        if (!o_ready) saw_ordy_low = 1;
        if (i_valid && o_ready) begin
          e = next_exp; e.cyc = cyc; e.lat = lat_chk; q.push_back(e);
        end
        if (held) chk("stall_hold", 64'({o_sat, o_data}), 64'(prev_out));
        held = o_valid && !i_ready;
        prev_out = {o_sat, o_data};
        chk("sat_cnt", 64'(o_sat_cnt), 64'(exp_cnt));
        fire = o_valid && i_ready;
        esat = 0;
        if (fire) begin
          nout++;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out actual=o_valid required=no_beat");
          end else begin
            e = q.pop_front();
            esat = |e.sat;
            chk("out_data", 64'(o_data), 64'(e.d));
            chk("out_sat", 64'(o_sat), 64'(e.sat));
            if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
          end
        end
        if (i_cnt_clr) exp_cnt = '0;
        else if (fire && esat && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [SHW-1:0] sh, input bit r, input exp_t e);
    int n = 0;
    next_exp = e; i_data = d; i_shift = sh; i_round = r; i_valid = 1;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
    if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
    @(posedge i_clk); #1;
    i_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o_valid) && n < 100) begin @(posedge i_clk); n++; end
    #1;
    if (n >= 100) chk("drain_timeout", 64'(n), 64'd0);
  endtask

  task automatic sat_beat(input int x);
    logic [DW-1:0] d; logic [SHW-1:0] sh; exp_t e;
    d = '0; d[IW-1:0] = IW'(x); sh = '0; sh[SW-1:0] = 4'd2;
    e = mk(d, sh, 1'b1);
    send(d, sh, 1'b1, e);
  endtask

  initial begin
    logic [DW-1:0] d; logic [SHW-1:0] sh; exp_t e; bit r; int n0;
    tbl[0]  = '{291, 2, 1, 73, 0};     tbl[1]  = '{291, 2, 0, 72, 0};
    tbl[2]  = '{-5, 1, 1, -2, 0};      tbl[3]  = '{-5, 1, 0, -3, 0};
    tbl[4]  = '{-32768, 15, 1, -1, 0}; tbl[5]  = '{100, 0, 1, 100, 0};
    tbl[6]  = '{100, 0, 0, 100, 0};    tbl[7]  = '{1000, 2, 1, 127, 1};
    tbl[8]  = '{-1000, 2, 1, -128, 1}; tbl[9]  = '{32767, 15, 1, 1, 0};
    tbl[10] = '{-1, 4, 1, 0, 0};       tbl[11] = '{-255, 1, 1, -127, 0};
    tbl[12] = '{-256, 1, 0, -128, 0};  tbl[13] = '{255, 1, 1, 127, 1};

    i_rst_n = 0; i_valid = 0; i_ready = 1; i_round = 0; i_cnt_clr = 0;
    i_data = '0; i_shift = '0; next_exp = '{'0, '0, 0, 0};
    fork monitor(); join_none
    #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_sat", 64'(o_sat), 64'd0);
    chk("rst_cnt", 64'(o_sat_cnt), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;

    // table vectors, one isolated beat each; lanes 1..3 carry zero
    for (int i = 0; i < 14; i++) begin
      d = '0; d[IW-1:0] = IW'(tbl[i].x);
      sh = 16'h3330; sh[SW-1:0] = SW'(tbl[i].sh);
      e.d = '0; e.d[OW-1:0] = OW'(tbl[i].exp);
      e.sat = '0; e.sat[0] = tbl[i].esat; e.cyc = 0; e.lat = 1;
      send(d, sh, tbl[i].rnd, e);
      repeat (3) @(posedge i_clk);
      #1;
    end
    drain();

    // two saturating beats after a clear
    i_cnt_clr = 1; @(posedge i_clk); #1; i_cnt_clr = 0;
    sat_beat(1000); sat_beat(-1000);
    drain();
    chk("cnt_two", 64'(o_sat_cnt), 64'd2);

    // 8-beat stream with a 3-cycle downstream stall mid-stream
    lat_chk = 0; saw_ordy_low = 0; n0 = nout;
    fork begin
      repeat (3) @(posedge i_clk); #1; i_ready = 0;
      repeat (3) @(posedge i_clk); #1; i_ready = 1;
    end join_none
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom}; sh = 16'($urandom); r = 1'($urandom);
      send(d, sh, r, mk(d, sh, r));
    end
    drain();
    chk("stream_count", 64'(nout - n0), 64'd8);
    chk("ready_dropped", 64'(saw_ordy_low), 64'd1);
    lat_chk = 1;

    // counter sticks at all-ones
    for (int i = 0; i < 17; i++) sat_beat(1000);
    drain();
    chk("cnt_stick", 64'(o_sat_cnt), 64'hF);

    // clear coincident with a saturating output transfer
    sat_beat(-1000);
    @(posedge i_clk); #1;
    chk("clr_pre_valid", 64'(o_valid), 64'd1);
    i_cnt_clr = 1;
    @(posedge i_clk); #1;
    i_cnt_clr = 0;
    chk("clr_priority", 64'(o_sat_cnt), 64'd0);
    drain();

    // reset with two beats in flight
    sat_beat(1000); sat_beat(500);
    #2; i_rst_n = 0; #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_data", 64'(o_data), 64'd0);
    chk("mid_rst_sat", 64'(o_sat), 64'd0);
    chk("mid_rst_cnt", 64'(o_sat_cnt), 64'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("no_ghost_valid", 64'(o_valid), 64'd0);
    end

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
